// File: rtl/path_dump_if.sv
// rtl/path_dump_if.sv - SRAM read bus and path-cell stream bundle for path_dump
interface path_dump_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  cs;
  logic                  we;
  logic                  path_valid;
  logic                  path_ready;
  logic [ADDR_WIDTH-1:0] path_addr;

  modport master (
    output address, cs, we, path_valid, path_addr,
    input  data_in, path_ready
  );

  modport slave (
    input  address, cs, we, path_valid, path_addr,
    output data_in, path_ready
  );
endinterface

// File: rtl/path_dump.sv
// rtl/path_dump.sv - scans the maze SRAM after routing and streams out every routed-path cell
module path_dump #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATH_MARK  = 8'h02
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              D,
  output logic              busy,
  output logic [ADDR_WIDTH:0] path_count,
  output logic              scan_done,
  path_dump_if.master       bus
);

  typedef enum logic [2:0] {IDLE, RD, CHK, OUT, FIN} state_t;

  state_t                state, state_nx;
  logic                  d_q;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  path_valid_q;
  logic [ADDR_WIDTH-1:0] path_addr_q;
  logic                  cs_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  trigger;
  logic                  match;
  logic                  last;
  logic                  handshake;

  assign trigger   = D && !d_q;
  assign match     = (bus.data_in == PATH_MARK);
  assign last      = &ptr;
  assign handshake = path_valid_q && bus.path_ready;

  assign bus.cs         = cs_c;
  assign bus.address    = addr_c;
  assign bus.we         = 1'b0;
  assign bus.path_valid = path_valid_q;
  assign bus.path_addr  = path_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cs_c     = 1'b0;
    addr_c   = '0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (trigger) state_nx = RD;
      end
      RD: begin
        cs_c     = 1'b1;
        addr_c   = ptr;
        state_nx = CHK;
      end
      CHK: begin
        if (match)     state_nx = OUT;
        else if (last) state_nx = FIN;
        else           state_nx = RD;
      end
      OUT: begin
        if (handshake) state_nx = last ? FIN : RD;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The address 255 cell ends the scan whether or not it matched, so the pointer never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q          <= 1'b0;
      ptr          <= '0;
      path_valid_q <= 1'b0;
      path_addr_q  <= '0;
      path_count   <= '0;
      scan_done    <= 1'b0;
    end else begin
      d_q       <= D;
      scan_done <= (state == FIN);
      case (state)
        IDLE: begin
          if (trigger) begin
            ptr        <= '0;
            path_count <= '0;
          end
        end
        CHK: begin
          if (match) begin
            path_addr_q  <= ptr;
            path_valid_q <= 1'b1;
            path_count   <= path_count + (ADDR_WIDTH+1)'(1);
          end else if (!last) begin
            ptr <= ptr + ADDR_WIDTH'(1);
          end
        end
        OUT: begin
          if (handshake) begin
            path_valid_q <= 1'b0;
            if (!last) ptr <= ptr + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/path_dump.md
PATH_DUMP -- requirements
Module: path_dump

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, SRAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, SRAM address width; grid cell = address, row = address[7:4], col = address[3:0].
REQ-003 SHALL have parameter PATH_MARK, default 8'h02, SRAM word value that marks a routed-path cell.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port D  input  1  router completion level from maze_router; scan triggers on its rising edge.
REQ-007 SHALL have port address  output  ADDR_WIDTH  SRAM read address.
REQ-008 SHALL have port data_in  input  DATA_WIDTH  SRAM data_out, valid one cycle after a read is issued.
REQ-009 SHALL have port cs  output  1  SRAM chip select.
REQ-010 SHALL have port we  output  1  SRAM write enable, tied 0 (block never writes).
REQ-011 SHALL have port busy  output  1  high while a scan is in progress; SRAM bus owned by this block.
REQ-012 SHALL have port path_valid  output  1  path cell offered downstream.
REQ-013 SHALL have port path_ready  input  1  downstream accepts path cell.
REQ-014 SHALL have port path_addr  output  ADDR_WIDTH  address of offered path cell.
REQ-015 SHALL have port path_count  output  ADDR_WIDTH+1  number of path cells emitted in current/last scan.
REQ-016 SHALL have port scan_done  output  1  one-cycle pulse at scan completion.

Function
REQ-017 SHALL implement FSM states IDLE, RD, CHK, OUT, FIN.
REQ-018 SHALL register D and detect rising edge (D=1, previous D=0) only in IDLE; in IDLE on edge: scan pointer:=0, path_count:=0, next RD.
REQ-019 SHALL in RD drive cs=1, we=0, address=pointer; next CHK.
REQ-020 SHALL in CHK compare data_in to PATH_MARK; match -> path_addr:=pointer, path_valid:=1, path_count+1, next OUT.
REQ-021 SHALL in CHK on mismatch: pointer = 2^ADDR_WIDTH-1 -> FIN, else pointer+1 -> RD.
REQ-022 SHALL in OUT hold path_valid and path_addr stable until path_valid&&path_ready; on handshake path_valid:=0 and advance as REQ-021.
REQ-023 SHALL in FIN assert scan_done for exactly one cycle, next IDLE.
REQ-024 SHALL drive cs=0 and address=0 in every state except RD.
REQ-025 SHALL assert busy in RD, CHK, OUT, FIN; deassert in IDLE.
REQ-026 SHALL ignore D edges while busy; a D held high after FIN SHALL NOT retrigger.
REQ-027 SHALL cost 2 cycles per non-matching cell; full scan with no matches = 512 cycles from trigger to FIN, scan_done the cycle after.
REQ-028 SHALL hold path_count after scan until next trigger; max value 256 fits ADDR_WIDTH+1 bits, no wrap.
REQ-029 SHALL scan pointer with no wrap; last address 255 terminates scan even if it matches (after its handshake).

Reset
REQ-030 SHALL on reset, asynchronously at any state incl. mid-scan or mid-handshake: state IDLE, pointer 0, address 0, cs 0, we 0, busy 0, path_valid 0, path_addr 0, path_count 0, scan_done 0, registered D 0.
REQ-031 SHALL after reset release with D already high treat that as a rising edge on first clock.

Verification
REQ-032 SHALL verify: SRAM preloaded all 0, D rises -> 256 reads, no path_valid, scan_done 513 cycles after trigger, path_count 0.
REQ-033 SHALL verify: cells 0x11,0x12,0x22 = 8'h02, path_ready=1 -> path_addr 0x11,0x12,0x22 in order, path_count 3.
REQ-034 SHALL verify: cell 0x40 matches, path_ready low 10 cycles -> path_valid and path_addr=0x40 stable 10 cycles, cs=0 throughout stall.
REQ-035 SHALL verify: cell 0xFF matches -> emitted last, scan_done one cycle after handshake, path_count 1.
REQ-036 SHALL verify: reset asserted mid-scan at pointer 0x80 -> all outputs zero immediately; second D pulse after release -> full rescan from 0x00.
REQ-037 SHALL verify: D pulses during busy -> no restart, single scan_done.
